// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM with a
// registered read. One access is in flight at a time: IDLE picks a
// winner, ISSUE drives the RAM for one cycle, CAPT catches read data, and
// ACK sets up a one-cycle completion pulse that is visible in the cycle
// after the FSM returns to IDLE.
module ram_arbiter #(
    parameter int AW = 5,
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          res,
    input  logic          req0,
    input  logic          req1,
    input  logic          wr0,
    input  logic          wr1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          ram_wr,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] CAPT  = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    logic [1:0]    state_reg;
    logic          sel_reg;     // latched winner: 0 = requester 0, 1 = requester 1
    logic          last_reg;    // requester served most recently
    logic          wr_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] din_reg;
    logic [DW-1:0] rdata0_reg;
    logic [DW-1:0] rdata1_reg;
    logic          ack0_reg;
    logic          ack1_reg;
    logic          grant_next;

    // Round-robin pick: a lone request wins, a tie goes to whoever was not served last.
    always_comb begin
        grant_next = req1;
        if (req0 && req1) begin
            grant_next = ~last_reg;
        end
    end

    // Access sequencer: state, winner latch and the round-robin pointer.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_reg <= IDLE;
            sel_reg   <= 1'b0;
            last_reg  <= 1'b1;
            wr_reg    <= 1'b0;
            addr_reg  <= '0;
            din_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req0 || req1) begin
                        sel_reg   <= grant_next;
                        last_reg  <= grant_next;
                        wr_reg    <= grant_next ? wr1 : wr0;
                        addr_reg  <= grant_next ? addr1 : addr0;
                        din_reg   <= grant_next ? din1 : din0;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE:   state_reg <= wr_reg ? ACK : CAPT;
                CAPT:    state_reg <= ACK;
                ACK:     state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Read-data capture: only the latched winner's result register is loaded.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            rdata0_reg <= '0;
            rdata1_reg <= '0;
        end else if (state_reg == CAPT) begin
            if (sel_reg) begin
                rdata1_reg <= ram_dout;
            end else begin
                rdata0_reg <= ram_dout;
            end
        end
    end

    // Completion pulse: armed on leaving ACK so it lasts exactly one cycle.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            ack0_reg <= 1'b0;
            ack1_reg <= 1'b0;
        end else begin
            ack0_reg <= (state_reg == ACK) && !sel_reg;
            ack1_reg <= (state_reg == ACK) && sel_reg;
        end
    end

    // RAM side is driven from the latch only, so it never follows the request inputs.
    assign ram_wr   = (state_reg == ISSUE) && wr_reg;
    assign ram_addr = addr_reg;
    assign ram_din  = din_reg;
    assign busy     = (state_reg != IDLE);
    assign ack0     = ack0_reg;
    assign ack1     = ack1_reg;
    assign rdata0   = rdata0_reg;
    assign rdata1   = rdata1_reg;

endmodule
